fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch front-end that sits directly upstream of the decoder. It owns the PC and issues in-order word fetches over a valid/ready request channel, holding at most FIFO_DEPTH fetches in flight or buffered. Returned words go into a prefetch FIFO, which presents {instr, instr_pc} to decode through a valid/ready handshake. It also handles redirects from execute, which flush the pipeline, and detects misaligned fetch targets.

Parameters:
XLEN, 32, width of the PC and of instructions.
RESET_PC, 32'h0000_0000, first fetch address after reset.
FIFO_DEPTH, 4, prefetch FIFO entries. Must be a power of 2, at least 2. Also the cap on outstanding requests.

Ports:
clk  in  1  core clock; all state on rising edge.
cpu_rst  in  1  asynchronous, active-high reset.
mem_req_valid  out  1  fetch request valid.
mem_req_ready  in  1  memory accepts the request this cycle.
mem_req_addr  out  XLEN  word-aligned fetch address.
mem_rsp_valid  in  1  read data valid. Responses are in order, at least 1 cycle after acceptance, and cannot be stalled.
mem_rsp_data  in  XLEN  fetched instruction word.
redirect_valid  in  1  one-cycle PC redirect from execute.
redirect_pc  in  XLEN  redirect target.
instr_valid  out  1  FIFO head valid toward decode.
instr_ready  in  1  decode accepts the head.
instr  out  XLEN  instruction word at the FIFO head.
instr_pc  out  XLEN  PC of that instruction.
fetch_misaligned  out  1  sticky flag: redirect target was not 4-byte aligned.

Behaviour:
- Reset (async assert, sync use after release):
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, state=RUN.
  - All outputs 0, except mem_req_addr=RESET_PC.
- Counters:
  - outstanding: accepted requests not yet responded to.
  - drop: responses still to be discarded.
  - Both are clog2(FIFO_DEPTH)+1 bits wide and never over/underflow.
- Request issue:
  - mem_req_valid = (state==RUN) && (outstanding + fifo_count < FIFO_DEPTH) && !redirect_valid.
  - mem_req_addr = fetch_pc.
  - On acceptance (valid && ready): outstanding++, fetch_pc += 4. Arithmetic wraps modulo 2^XLEN.
  - While valid is high and ready is low, the address is held stable.
- Response handling:
  - On mem_rsp_valid: outstanding--.
  - If drop>0, drop-- and the data is discarded.
  - Otherwise push {mem_rsp_data, pc} into the FIFO. The pc is taken from a per-entry address tag pipeline, or equivalently a response-PC register that increments by 4 per push.
  - The credit rule guarantees the FIFO never overflows.
- Output:
  - instr_valid = FIFO not empty; instr/instr_pc come from the head.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - A response arriving in cycle N is visible at instr_valid in cycle N+1.
  - Fetch-to-decode latency = memory latency + 1.
- Redirect (redirect_valid=1 in cycle N):
  - FIFO flushed at the edge ending N. A pop in N still completes.
  - drop = all requests in flight after N, i.e. outstanding plus any request accepted in N, minus any non-dropped response in N. A response arriving in N is discarded.
  - If redirect_pc[1:0]==0: fetch_pc=redirect_pc, state=RUN, fetch_misaligned=0. The first new request is issued in N+1.
  - Otherwise: state=FAULT, fetch_misaligned=1, fetch_pc=redirect_pc.
  - A redirect in cycle N also overrides any pending issue in N.
- State machine:
  - RUN: issues requests as above.
  - FAULT: no new requests; drains and drops in-flight responses; FIFO stays empty; fetch_misaligned held at 1.
  - Only an aligned redirect leaves FAULT.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset are ignored while outstanding==0, which prevents counter underflow.

Optional Feature:
FETCH_PERF_EN
- Defined: adds two outputs, perf_instr_cnt (32-bit) and perf_flush_cnt (32-bit).
  - perf_instr_cnt increments on each instr handshake.
  - perf_flush_cnt increments on each redirect_valid cycle.
  - Both wrap, and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, memory with 1-cycle latency, ready=1, instr_ready=1 -> first request at addr 0x0 the cycle after reset release; instr_pc sequence 0x0, 0x4, 0x8, 0xC, one per cycle, with no bubbles after fill.
2. instr_ready=0, FIFO_DEPTH=4 -> exactly 4 requests (0x0–0xC) accepted, then mem_req_valid=0. Raising instr_ready resumes at 0x10 with no lost or duplicated PCs.
3. mem_req_ready held low 3 cycles -> mem_req_valid=1 and mem_req_addr=0x0 stable throughout; outstanding unchanged.
4. Redirect to 0x100 with 2 requests outstanding (memory latency 3) -> both old responses dropped; next instr_pc=0x100, then 0x104. No stale word reaches decode.
5. Redirect to 0x102 -> fetch_misaligned=1, no requests, instr_valid=0. A later redirect to 0x200 clears the flag and the next instr_pc=0x200.
6. cpu_rst asserted with 3 requests outstanding and the FIFO half full -> outputs clear asynchronously. After release, fetch restarts at RESET_PC and stray late responses produce no instr_valid.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front-end with credit-limited requests and prefetch FIFO
// Optional FETCH_PERF_EN adds perf_instr_cnt / perf_flush_cnt.
module fetch_unit #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = 32'h0000_0000,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             cpu_rst,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [XLEN-1:0]  mem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc,
    output logic             fetch_misaligned
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_instr_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            run;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   out_nxt;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   count_nxt;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW:0]     credit_used;

    logic [XLEN-1:0] mem_instr [FIFO_DEPTH];
    logic [XLEN-1:0] mem_pc    [FIFO_DEPTH];

    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;

    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) state <= RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = (redirect_pc[1:0] == 2'b00) ? RUN : FAULT;
    end

    always_comb begin
        run              = (state == RUN);
        fetch_misaligned = (state == FAULT);
    end

    assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};
    // Gating with cpu_rst keeps the request channel quiet while reset is held.
    assign mem_req_valid = !cpu_rst && run && (credit_used < DEPTH_C) && !redirect_valid;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Responses with nothing outstanding are strays from before a reset.
    assign rsp_fire = mem_rsp_valid && (outstanding != '0);
    assign rsp_drop = rsp_fire && (drop != '0);
    assign push     = rsp_fire && !rsp_drop && run && !redirect_valid;
    assign pop      = instr_valid && instr_ready;

    always_comb begin
        out_nxt = outstanding;
        if (req_fire && !rsp_fire)
            out_nxt = outstanding + CW'(1);
        else if (!req_fire && rsp_fire)
            out_nxt = outstanding - CW'(1);
    end

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop)
            count_nxt = fifo_count + CW'(1);
        else if (!push && pop)
            count_nxt = fifo_count - CW'(1);
    end

    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= out_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc   <= redirect_pc;
                rsp_pc     <= redirect_pc;
                drop       <= out_nxt;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
                if (rsp_drop) drop     <= drop - CW'(1);
                if (push)     wr_ptr   <= wr_ptr + AW'(1);
                if (pop)      rd_ptr   <= rd_ptr + AW'(1);
                fifo_count <= count_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= mem_rsp_data;
            mem_pc[wr_ptr]    <= rsp_pc;
        end
    end

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? mem_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            perf_instr_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop)            perf_instr_cnt <= perf_instr_cnt + 32'(1);
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'(1);
        end
    end
`endif

endmodule
